// File: rtl/moore_seq_detector_if.sv
// Bus bundle for moore_seq_detector: serial input, configuration and status.
// The master side drives data/config and reads status; the slave is the detector.
interface moore_seq_detector_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int FILL_W = $clog2(N + 1);

  logic              din;
  logic              din_valid;
  logic              cfg_load;
  logic [N-1:0]      cfg_pattern;
  logic              overlap;
  logic              clr_count;

  logic              match;
  logic [CNT_W-1:0]  match_count;
  logic [FILL_W-1:0] fill;
  logic [1:0]        state;

  modport master (
    output din, din_valid, cfg_load, cfg_pattern, overlap, clr_count,
    input  match, match_count, fill, state
  );

  modport slave (
    input  din, din_valid, cfg_load, cfg_pattern, overlap, clr_count,
    output match, match_count, fill, state
  );
endinterface

// File: rtl/moore_seq_detector.sv
// Moore-style serial pattern detector: programmable N-bit pattern, qualified input,
// overlapping / non-overlapping detection and a saturating match counter.
module moore_seq_detector #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  moore_seq_detector_if.slave  bus
);

  localparam int FW = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_MATCH  = 2'd2
  } state_e;

  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("moore_seq_detector: N must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
      $error("moore_seq_detector: CNT_W must be in 1..16");
    end
  endgenerate

  state_e           r_state;
  logic [N-1:0]     r_pattern;
  logic [N-1:0]     r_hist;
  logic [FW-1:0]    r_fill;
  logic [CNT_W-1:0] r_count;

  state_e           w_state_nx;
  logic [N-1:0]     w_hist_nx;
  logic [FW-1:0]    w_fill_nx;
  logic [N-1:0]     w_hist_d;
  logic [FW-1:0]    w_fill_d;
  logic             w_accept;
  logic             w_hit;
  logic             w_enter_match;
  logic             w_count_sat;

  // Candidate history/fill as if the current bit were accepted.
  assign w_accept  = bus.din_valid && !bus.cfg_load;
  assign w_hist_nx = (r_hist << 1) | N'(bus.din);
  assign w_fill_nx = (r_fill == FW'(N)) ? r_fill : r_fill + FW'(1);
  assign w_hit     = w_accept && (w_fill_nx == FW'(N)) && (w_hist_nx == r_pattern);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_hist_d   = r_hist;
    w_fill_d   = r_fill;

    if (bus.cfg_load) begin
      w_state_nx = ST_IDLE;
      w_hist_d   = '0;
      w_fill_d   = '0;
    end else if (bus.din_valid) begin
      w_state_nx = w_hit ? ST_MATCH : ST_SEARCH;
      // Non-overlap mode restarts collection from scratch after a hit.
      if (w_hit && !bus.overlap) begin
        w_hist_d = '0;
        w_fill_d = '0;
      end else begin
        w_hist_d = w_hist_nx;
        w_fill_d = w_fill_nx;
      end
    end else if (r_state == ST_MATCH) begin
      w_state_nx = ST_SEARCH;
    end
  end

  assign w_enter_match = (w_state_nx == ST_MATCH);
  assign w_count_sat   = (r_count == {CNT_W{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_hist  <= w_hist_d;
      r_fill  <= w_fill_d;
      if (bus.cfg_load) begin
        r_pattern <= bus.cfg_pattern;
      end
      // Clearing wins over a simultaneous hit; that hit is simply not counted.
      if (bus.clr_count) begin
        r_count <= '0;
      end else if (w_enter_match && !w_count_sat) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.match       = (r_state == ST_MATCH);
  assign bus.state       = r_state;
  assign bus.fill        = r_fill;
  assign bus.match_count = r_count;

  // Structural invariants of the machine.
  a_state_legal: assert property (@(posedge clk) disable iff (rst)
    r_state inside {ST_IDLE, ST_SEARCH, ST_MATCH});

  a_fill_range: assert property (@(posedge clk) disable iff (rst)
    r_fill <= FW'(N));

  a_load_idle: assert property (@(posedge clk) disable iff (rst)
    bus.cfg_load |=> (r_state == ST_IDLE) && (r_fill == '0));

  a_count_clr: assert property (@(posedge clk) disable iff (rst)
    bus.clr_count |=> (r_count == '0));

  a_count_mono: assert property (@(posedge clk) disable iff (rst)
    !bus.clr_count |=> (r_count >= $past(r_count)));

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench for moore_seq_detector: two instances (wide and 2-bit counter)
// share stimulus; a queue-based reference model predicts every cycle's outputs.
module tb_moore_seq_detector;

  localparam int N       = 4;
  localparam int CNT_W_A = 8;
  localparam int CNT_W_B = 2;
  localparam int MAX_A   = (1 << CNT_W_A) - 1;
  localparam int MAX_B   = (1 << CNT_W_B) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  moore_seq_detector_if #(.N(N), .CNT_W(CNT_W_A)) bus_a ();
  moore_seq_detector_if #(.N(N), .CNT_W(CNT_W_B)) bus_b ();

  moore_seq_detector #(.N(N), .CNT_W(CNT_W_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  moore_seq_detector #(.N(N), .CNT_W(CNT_W_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    int id;
    int match;
    int state;
    int fill;
    int cnt_a;
    int cnt_b;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  // Reference model: the accepted bits since the last clear, newest at the back.
  bit acc_q[$];
  int m_pattern = 0;
  bit m_idle    = 1'b1;
  bit m_match   = 1'b0;
  int m_cnt_a   = 0;
  int m_cnt_b   = 0;

  task automatic check(input string name, input int id,
                       input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", name, id, actual, expected);
    end
  endtask

  task automatic model(input bit r, input bit ld, input int pat,
                       input bit v, input bit d, input bit ov, input bit clr);
    bit hit = 1'b0;
    int win = 0;
    if (r) begin
      acc_q.delete();
      m_pattern = 0;
      m_idle    = 1'b1;
      m_match   = 1'b0;
      m_cnt_a   = 0;
      m_cnt_b   = 0;
      return;
    end
    if (ld) begin
      m_pattern = pat;
      acc_q.delete();
      m_idle  = 1'b1;
      m_match = 1'b0;
    end else if (v) begin
      acc_q.push_back(d);
      if (acc_q.size() > N) void'(acc_q.pop_front());
      foreach (acc_q[i]) win = win * 2 + int'(acc_q[i]);
      hit = (acc_q.size() == N) && (win == m_pattern);
      if (hit && !ov) acc_q.delete();
      m_idle  = 1'b0;
      m_match = hit;
    end else begin
      m_match = 1'b0;
    end
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (hit) begin
      if (m_cnt_a < MAX_A) m_cnt_a++;
      if (m_cnt_b < MAX_B) m_cnt_b++;
    end
  endtask

  task automatic step(input bit r, input bit ld, input int pat,
                      input bit v, input bit d, input bit ov, input bit clr);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus_a.cfg_load    = ld;  bus_b.cfg_load    = ld;
    bus_a.cfg_pattern = N'(pat); bus_b.cfg_pattern = N'(pat);
    bus_a.din_valid   = v;   bus_b.din_valid   = v;
    bus_a.din         = d;   bus_b.din         = d;
    bus_a.overlap     = ov;  bus_b.overlap     = ov;
    bus_a.clr_count   = clr; bus_b.clr_count   = clr;
    model(r, ld, pat, v, d, ov, clr);
    e.id    = step_id++;
    e.match = int'(m_match);
    e.state = m_idle ? 0 : (m_match ? 2 : 1);
    e.fill  = acc_q.size();
    e.cnt_a = m_cnt_a;
    e.cnt_b = m_cnt_b;
    sb_q.push_back(e);
  endtask

  task automatic load(input int pat);
    step(1'b0, 1'b1, pat, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends n bits of 'bits', MSB first; 'gap' inserts an invalid cycle after each bit.
  task automatic send(input int bits, input int n, input bit ov, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b0, 0, 1'b1, bits[i], ov, 1'b0);
      if (gap) step(1'b0, 1'b0, 0, 1'b0, 1'b0, ov, 1'b0);
    end
  endtask

  // Monitor: an expectation pushed before an edge is checked on the following negedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        @(negedge clk);
        check("match",       e.id, 32'(bus_a.match),       32'(e.match));
        check("state",       e.id, 32'(bus_a.state),       32'(e.state));
        check("fill",        e.id, 32'(bus_a.fill),        32'(e.fill));
        check("match_count", e.id, 32'(bus_a.match_count), 32'(e.cnt_a));
        check("sat_count",   e.id, 32'(bus_b.match_count), 32'(e.cnt_b));
        check("sat_match",   e.id, 32'(bus_b.match),       32'(e.match));
      end
    end
  end

  initial begin
    bus_a.din = 1'b0; bus_a.din_valid = 1'b0; bus_a.cfg_load = 1'b0;
    bus_a.cfg_pattern = '0; bus_a.overlap = 1'b0; bus_a.clr_count = 1'b0;
    bus_b.din = 1'b0; bus_b.din_valid = 1'b0; bus_b.cfg_load = 1'b0;
    bus_b.cfg_pattern = '0; bus_b.overlap = 1'b0; bus_b.clr_count = 1'b0;

    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Overlapping and non-overlapping 1011 over 1011011.
    load(4'b1011);
    send(7'b1011011, 7, 1'b1, 1'b0);
    load(4'b1011);
    send(7'b1011011, 7, 1'b0, 1'b0);
    idle(1);

    // Run of ones, both modes.
    load(4'b1111);
    send(8'hFF, 8, 1'b1, 1'b0);
    load(4'b1111);
    send(8'hFF, 8, 1'b0, 1'b0);
    idle(1);

    // Gapped stream, then cfg_load colliding with a valid bit.
    load(4'b1011);
    send(7'b1011011, 7, 1'b1, 1'b1);
    send(3'b101, 3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
    send(4'b1011, 4, 1'b1, 1'b0);

    // Saturation from zero, then clr_count on a match edge.
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    load(4'b1111);
    send(9'h1FF, 9, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    send(2'b11, 2, 1'b1, 1'b0);

    // Reset mid-stream, reload, full pattern.
    load(4'b1011);
    send(3'b101, 3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    load(4'b1011);
    send(4'b1011, 4, 1'b1, 1'b0);
    idle(2);

    // Randomised traffic with occasional reconfiguration, clears and resets.
    for (int i = 0; i < 800; i++) begin
      int sel = $urandom_range(0, 199);
      if (sel == 0)
        step(1'b1, 1'b0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      else if (sel < 6)
        step(1'b0, 1'b1, int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0));
      else
        step(1'b0, 1'b0, 0, 1'($urandom_range(0, 3) != 0), 1'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drain", step_id, 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
